mem_periph_ctrl: RTL
====================

# mem_periph_ctrl

Parametrised successor to the integrated memory/peripheral controller. It translates 32-bit virtual byte addresses into three regions: on-chip text RAM, on-chip data RAM, and an external IO bus. It adds a request/ready handshake, byte-lane writes, a wait-state IO handshake with timeout, and a fault response for unmapped, misaligned or protected accesses. It sits between the CPU load/store stage and the peripheral fabric.

## Interface
- TEXT_DEPTH, 256: text RAM words; power of two.
- DATA_DEPTH, 1024: data RAM words; power of two.
- TEXT_WRITABLE, 1: 1 allows writes to text; 0 makes text writes fault.
- IO_TIMEOUT, 15: maximum cycles spent in IO_WAIT before a fault; 1..255.

Ports:
- clk  in  1  Clock; all state changes on the rising edge.
- rstVirt  in  1  One clock; reset is asynchronous and active-low.
- reqVirt  in  1  Request valid.
- wEnVirt  in  1  1 = write, 0 = read. Sampled with the request.
- byteEnVirt  in  4  Write byte lanes (bit i covers data[8i+7:8i]). Ignored on reads.
- addressVirt  in  32  Virtual byte address.
- dataInVirt  in  32  Write data.
- readyVirt  out  1  Controller can accept a request.
- doneVirt  out  1  One-cycle completion pulse, one per accepted request.
- faultVirt  out  1  Valid with doneVirt; 1 = access rejected.
- dataOutVirt  out  32  Read data; valid with doneVirt on a read.
- ioReq  out  1  IO access pending.
- ioWEn  out  1  IO write.
- ioByteEn  out  4  IO write lanes.
- ioAddr  out  16  IO register offset (addressVirt[15:0]).
- ioWData  out  32  IO write data.
- ioAck  in  1  Peripheral completion.
- ioRData  in  32  Peripheral read data; sampled on ioAck.

## Operation
Address decode is evaluated on the accept cycle. Priority is top to bottom:
- addressVirt[1:0] != 0: fault (misaligned).
- 0x0000_0000..0x0FFF_FFFF: text region, word index = addr[31:2].
  - Index >= TEXT_DEPTH: fault.
  - Write with TEXT_WRITABLE=0: fault.
- 0x1000_0000..0x7FFF_FFFF: data region, word index = (addr - 0x1000_0000) >> 2.
  - Index >= DATA_DEPTH: fault.
- 0xFFFF_0000..0xFFFF_FFFF: IO region.
- All other addresses (0x8000_0000..0xFFFE_FFFF): fault.

Fault behaviour:
- No RAM write and no IO cycle.
- dataOutVirt = 0.
- Response timing is the same as a RAM access.

RAM write:
- Only lanes with byteEnVirt set are updated.
- byteEnVirt = 0 is a legal no-op that completes without fault.

RAM read returns the full word.

State machine (IDLE is the reset state):
- IDLE: readyVirt = 1. On reqVirt:
  - RAM access or fault: go to RESP.
  - IO access: go to IO_WAIT.
- IO_WAIT: ioReq = 1, and ioWEn, ioByteEn, ioAddr and ioWData are held stable from the request. The timeout counter starts at 0.
  - ioAck: capture ioRData (reads only), go to RESP with fault = 0.
  - Counter reaches IO_TIMEOUT without ioAck: go to RESP with fault = 1, dataOutVirt = 0.
  - Otherwise: increment the counter.
- RESP: doneVirt = 1, readyVirt = 0, then go to IDLE.

Other rules:
- RAM contents are not cleared by reset.
- Read-during-write cannot occur, because only one request is outstanding.

## Timing
Reset values:
- readyVirt = 1.
- doneVirt, faultVirt, dataOutVirt, ioReq, ioWEn, ioByteEn, ioAddr, ioWData = 0.
- State = IDLE; timeout counter = 0.

Latency:
- Accept happens on the edge where reqVirt & readyVirt.
- RAM access or fault: accept at edge N, doneVirt high in cycle N+1, readyVirt high again in cycle N+2. Throughput is one access per 2 cycles.
- IO access: ioReq rises in cycle N+1. If ioAck is sampled at edge M, doneVirt is high in cycle M+1.
- Minimum IO latency is 2 cycles (ack in the first IO_WAIT cycle).
- Timeout: doneVirt (with fault) in cycle N+IO_TIMEOUT+2.
- ioReq deasserts in the same cycle doneVirt asserts.

Handshake and boundary rules:
- reqVirt while readyVirt = 0 is ignored, not queued.
- An ioAck arriving on the same edge as the timeout wins: success, no fault.
- An ioAck outside IO_WAIT is ignored.
- Reset asserted mid-operation: IDLE immediately (asynchronous); ioReq drops without an edge; the pending request is lost with no done pulse; a RAM write in flight does not commit after reset.
- dataOutVirt and faultVirt hold their values until the next doneVirt.

## Test plan
- Reset, then write 0xA5A5_A5A5 to 0x0000_0000 with byteEn 0xF, then read it back -> done one cycle after each accept, read data 0xA5A5_A5A5, fault 0.
- Write 0x1234_5678 to 0x1000_0004, then write 0xFFFF_FFFF with byteEn 0x2, then read -> 0x1234_FF78.
- Access 0x0000_0002, 0x7FFF_FFFC (beyond DATA_DEPTH) and 0x8000_0000 -> each gives done with fault 1, data 0, and no RAM change.
- IO write of 0xDEAD_BEEF to 0xFFFF_0010 with ioAck after 3 cycles -> ioAddr 0x0010 and ioWData held for the whole wait, done 1 cycle after ack, fault 0.
- IO read with no ack -> fault in cycle N+IO_TIMEOUT+2 with ioReq dropped. Repeat with ack on the timeout edge -> no fault, ioRData returned.
- Assert rstVirt low during IO_WAIT and during RESP -> ioReq and doneVirt drop immediately, readyVirt = 1, and no done pulse follows release.

Source files
------------

// File: rtl/mem_periph_ctrl.sv
// Memory/peripheral controller: decodes CPU byte addresses into text RAM, data RAM
// and a wait-state IO bus, with byte-lane writes, IO timeout and fault responses.
module mem_periph_ctrl #(
  parameter int unsigned TEXT_DEPTH    = 256,
  parameter int unsigned DATA_DEPTH    = 1024,
  parameter bit          TEXT_WRITABLE = 1'b1,
  parameter int unsigned IO_TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rstVirt,
  input  logic        reqVirt,
  input  logic        wEnVirt,
  input  logic [3:0]  byteEnVirt,
  input  logic [31:0] addressVirt,
  input  logic [31:0] dataInVirt,
  output logic        readyVirt,
  output logic        doneVirt,
  output logic        faultVirt,
  output logic [31:0] dataOutVirt,
  output logic        ioReq,
  output logic        ioWEn,
  output logic [3:0]  ioByteEn,
  output logic [15:0] ioAddr,
  output logic [31:0] ioWData,
  input  logic        ioAck,
  input  logic [31:0] ioRData
);

  localparam int unsigned TAW = (TEXT_DEPTH > 1) ? $clog2(TEXT_DEPTH) : 1;
  localparam int unsigned DAW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [7:0]  TIMEOUT_CNT = 8'(IO_TIMEOUT);

  typedef enum logic [1:0] {IDLE, IO_WAIT, RESP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] text_ram [TEXT_DEPTH];
  logic [31:0] data_ram [DATA_DEPTH];

  logic [29:0] text_idx;
  logic [29:0] data_idx;
  logic        misaligned, in_text, in_data, in_io;
  logic        use_text, use_data, use_io;

  // RAM writes are deferred to the RESP edge so a reset during RESP cancels them
  logic           wr_text, wr_data;
  logic [TAW-1:0] wr_tidx;
  logic [DAW-1:0] wr_didx;
  logic [31:0]    wr_word;
  logic [3:0]     wr_be;

  assign text_idx = addressVirt[31:2];
  assign data_idx = addressVirt[31:2] - 30'h0400_0000;

  always_comb begin
    misaligned = |addressVirt[1:0];
    in_text    = (addressVirt[31:28] == 4'h0);
    in_data    = !addressVirt[31] && !in_text;
    in_io      = (addressVirt[31:16] == 16'hFFFF);
    use_text   = !misaligned && in_text && ({2'b00, text_idx} < TEXT_DEPTH)
                 && (!wEnVirt || TEXT_WRITABLE);
    use_data   = !misaligned && in_data && ({2'b00, data_idx} < DATA_DEPTH);
    use_io     = !misaligned && in_io;
  end

  always_ff @(posedge clk or negedge rstVirt) begin
    if (!rstVirt) begin
      state       <= IDLE;
      cnt         <= '0;
      readyVirt   <= 1'b1;
      doneVirt    <= 1'b0;
      faultVirt   <= 1'b0;
      dataOutVirt <= '0;
      ioReq       <= 1'b0;
      ioWEn       <= 1'b0;
      ioByteEn    <= '0;
      ioAddr      <= '0;
      ioWData     <= '0;
      wr_text     <= 1'b0;
      wr_data     <= 1'b0;
      wr_tidx     <= '0;
      wr_didx     <= '0;
      wr_word     <= '0;
      wr_be       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reqVirt) begin
            readyVirt <= 1'b0;
            if (use_io) begin
              state    <= IO_WAIT;
              cnt      <= '0;
              ioReq    <= 1'b1;
              ioWEn    <= wEnVirt;
              ioByteEn <= byteEnVirt;
              ioAddr   <= addressVirt[15:0];
              ioWData  <= dataInVirt;
            end else begin
              state     <= RESP;
              doneVirt  <= 1'b1;
              faultVirt <= !(use_text || use_data);
              if (use_text && !wEnVirt)
                dataOutVirt <= text_ram[text_idx[TAW-1:0]];
              else if (use_data && !wEnVirt)
                dataOutVirt <= data_ram[data_idx[DAW-1:0]];
              else
                dataOutVirt <= '0;
              wr_text <= use_text && wEnVirt;
              wr_data <= use_data && wEnVirt;
              wr_tidx <= text_idx[TAW-1:0];
              wr_didx <= data_idx[DAW-1:0];
              wr_word <= dataInVirt;
              wr_be   <= byteEnVirt;
            end
          end
        end
        IO_WAIT: begin
          // ack on the timeout edge takes precedence over the timeout
          if (ioAck) begin
            state       <= RESP;
            doneVirt    <= 1'b1;
            faultVirt   <= 1'b0;
            dataOutVirt <= ioWEn ? '0 : ioRData;
            ioReq       <= 1'b0;
          end else if (cnt == TIMEOUT_CNT) begin
            state       <= RESP;
            doneVirt    <= 1'b1;
            faultVirt   <= 1'b1;
            dataOutVirt <= '0;
            ioReq       <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          doneVirt  <= 1'b0;
          readyVirt <= 1'b1;
          wr_text   <= 1'b0;
          wr_data   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          doneVirt  <= 1'b0;
          readyVirt <= 1'b1;
          ioReq     <= 1'b0;
          wr_text   <= 1'b0;
          wr_data   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (wr_text && wr_be[i])
        text_ram[wr_tidx][8*i +: 8] <= wr_word[8*i +: 8];
      if (wr_data && wr_be[i])
        data_ram[wr_didx][8*i +: 8] <= wr_word[8*i +: 8];
    end
  end

endmodule
